// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Brief    : Operand/op-select and result/flag bundle for the datapath ALU.
//            The master side drives operands and the control code; the slave
//            (the ALU) returns the registered result and status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_if #(
  parameter int WIDTH = 62
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       control;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output a, b, control,
    input  result, zero, carry, overflow
  );

  modport slave (
    input  a, b, control,
    output result, zero, carry, overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Registered integer ALU (AND/OR/ADD/SUB/NONE) selected by a 4-bit
//            MIPS-style control code. Result and zero/carry/overflow flags are
//            computed combinationally and registered with one cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int WIDTH = 62
) (
  input wire    clk,
  input wire    rst,
  alu_if.slave  bus
);

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_sub  = 4'b0110;

  // Both arithmetic paths carry one extra bit so the carry-out is visible.
  // Subtraction is a + ~b + 1; its carry-out is the inverse of the borrow.
  logic [WIDTH:0]   w_add_full;
  logic [WIDTH:0]   w_sub_full;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;

  assign w_add_full = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub_full = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

  // Next-state result and flags; unused and illegal codes fall to idle (all 0).
  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (bus.control)
      c_op_and: w_result = bus.a & bus.b;
      c_op_or:  w_result = bus.a | bus.b;
      c_op_add: begin
        w_result   = w_add_full[WIDTH-1:0];
        w_carry    = w_add_full[WIDTH];
        w_overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (w_add_full[WIDTH-1] != bus.a[WIDTH-1]);
      end
      c_op_sub: begin
        w_result   = w_sub_full[WIDTH-1:0];
        w_carry    = ~w_sub_full[WIDTH];
        w_overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (w_sub_full[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
      end
    endcase
    w_zero = (w_result == '0);
  end

  // Output register; reset forces the idle state (zero flag set).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_zero     <= w_zero;
      r_carry    <= w_carry;
      r_overflow <= w_overflow;
    end
  end

  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Directed and randomized checks of the registered ALU: reset,
//            each op, wrap/borrow, signed overflow, illegal codes, back-to-back
//            throughput and a mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  localparam int WIDTH = 62;

  localparam logic [3:0] c_and  = 4'b0000;
  localparam logic [3:0] c_or   = 4'b0001;
  localparam logic [3:0] c_add  = 4'b0010;
  localparam logic [3:0] c_sub  = 4'b0110;
  localparam logic [3:0] c_none = 4'b0111;

  localparam logic [WIDTH-1:0] c_ones    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_min_neg = 62'h2000_0000_0000_0000;
  localparam logic [WIDTH-1:0] c_max_pos = 62'h1FFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed overflow judged by range of the exact 64-bit result,
  // borrow by unsigned magnitude compare.
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [3:0] op);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    longint           sx;
    longint           sy;
    longint           st;
    longint           maxv;
    longint           minv;
    maxv = 64'sh1FFF_FFFF_FFFF_FFFF;
    minv = -64'sh2000_0000_0000_0000;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        full = {1'b0, x} + {1'b0, y};
        r = full[WIDTH-1:0];
        c = full[WIDTH];
        st = sx + sy;
        o = (st > maxv) || (st < minv);
      end
      4'b0110: begin
        r = x - y;
        c = (x < y);
        st = sx - sy;
        o = (st > maxv) || (st < minv);
      end
      default: r = '0;
    endcase
    return {r, (r == '0), c, o};
  endfunction

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [3:0] op);
    bus.a       = x;
    bus.b       = y;
    bus.control = op;
  endtask

  // Advance one edge and compare {result, zero, carry, overflow} #1 later.
  task automatic tick_check(input string tag, input logic [WIDTH+2:0] exp);
    logic [WIDTH+2:0] obs;
    @(posedge clk);
    #1;
    obs = {bus.result, bus.zero, bus.carry, bus.overflow};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed res=%h z=%b c=%b v=%b expected res=%h z=%b c=%b v=%b",
             tag, obs[WIDTH+2:3], obs[2], obs[1], obs[0],
             exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    logic [63:0]      t64;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [3:0]       rop;
    logic [3:0]       ops [8];
    vectors     = 0;
    miscompares = 0;
    ops = '{c_and, c_or, c_add, c_sub, c_none, c_add, c_sub, 4'b1111};

    // Reset held for two edges while an ADD is presented.
    rst = 1'b1;
    drive(62'd5, 62'd3, c_add);
    tick_check("reset_edge1", {62'd0, 1'b1, 1'b0, 1'b0});
    tick_check("reset_edge2", {62'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    tick_check("post_reset_add", {62'd8, 1'b0, 1'b0, 1'b0});

    // One operand pair through each op on consecutive cycles.
    drive(62'd2, 62'd1, c_and);
    tick_check("and_2_1", {62'd0, 1'b1, 1'b0, 1'b0});
    drive(62'd2, 62'd1, c_or);
    tick_check("or_2_1", {62'd3, 1'b0, 1'b0, 1'b0});
    drive(62'd2, 62'd1, c_add);
    tick_check("add_2_1", {62'd3, 1'b0, 1'b0, 1'b0});
    drive(62'd2, 62'd1, c_sub);
    tick_check("sub_2_1", {62'd1, 1'b0, 1'b0, 1'b0});
    drive(62'd2, 62'd1, c_none);
    tick_check("none_2_1", {62'd0, 1'b1, 1'b0, 1'b0});

    // Wrap and borrow.
    drive(c_ones, 62'd1, c_add);
    tick_check("add_wrap", {62'd0, 1'b1, 1'b1, 1'b0});
    drive(62'd1, 62'd2, c_sub);
    tick_check("sub_borrow", {c_ones, 1'b0, 1'b1, 1'b0});

    // Signed overflow.
    drive(c_max_pos, 62'd1, c_add);
    tick_check("add_ovf", {c_min_neg, 1'b0, 1'b0, 1'b1});
    drive(c_min_neg, 62'd1, c_sub);
    tick_check("sub_ovf", {c_max_pos, 1'b0, 1'b0, 1'b1});

    // Illegal code, then wide bit patterns for the logic ops.
    drive(62'd7, 62'd7, 4'b1111);
    tick_check("illegal_1111", {62'd0, 1'b1, 1'b0, 1'b0});
    drive(62'h2AAA_AAAA_AAAA_AAAA, c_ones, c_and);
    tick_check("and_pattern", {62'h2AAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, 1'b0});
    drive(62'h2AAA_AAAA_AAAA_AAAA, 62'h1555_5555_5555_5555, c_or);
    tick_check("or_pattern", {c_ones, 1'b0, 1'b0, 1'b0});
    drive(62'd9, 62'd9, c_sub);
    tick_check("sub_equal", {62'd0, 1'b1, 1'b0, 1'b0});

    // Back-to-back random stream with a single-edge reset in the middle.
    for (int i = 0; i < 1000; i++) begin
      t64 = {$urandom, $urandom};
      ra  = t64[WIDTH-1:0];
      t64 = {$urandom, $urandom};
      rb  = t64[WIDTH-1:0];
      case ($urandom_range(0, 7))
        0: ra = c_max_pos;
        1: ra = c_min_neg;
        2: rb = c_ones;
        3: rb = ra;
        default: ;
      endcase
      rop = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) rop = 4'($urandom_range(0, 15));
      drive(ra, rb, rop);
      if (i == 500) begin
        rst = 1'b1;
        tick_check("rand_midreset", {62'd0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0;
      end else begin
        tick_check("rand", model(ra, rb, rop));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
